// File: rtl/fetch_reader.sv
// Instruction-fetch reader: issues byte reads over req/ack, buffers {byte, address}
// pairs in a prefetch FIFO for the decoder, and flushes everything stale on a load.
module fetch_reader #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_addr,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        instr_valid,
   output logic [7:0]  instr_data,
   output logic [15:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state;
   logic [15:0]     fetch_ptr;
   logic [7:0]      fifo_data [DEPTH];
   logic [15:0]     fifo_pc   [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW:0]     count;

   logic            push;
   logic            pop;
   logic [PW:0]     count_after;

   // A load overrides both the push of an acked byte and a decoder pop.
   always_comb begin
      push        = (state == REQ) && mem_ack && !load;
      pop         = (count != '0) && instr_ready && !load;
      count_after = count + (PW+1)'(push) - (PW+1)'(pop);
   end

   assign instr_valid = (count != '0);
   assign instr_data  = fifo_data[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= 16'h0000;
         fetch_ptr <= 16'h0000;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= 8'h00;
            fifo_pc[i]   <= 16'h0000;
         end
      end else if (load) begin
         rd_ptr    <= wr_ptr;
         count     <= '0;
         fetch_ptr <= load_addr;
         // An unacked request must stay on the bus; it is retired in DISCARD instead.
         if (state == IDLE || mem_ack) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= load_addr;
         end else begin
            state <= DISCARD;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= mem_addr;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_after;

         case (state)
            IDLE: begin
               if (count < FULL) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_ptr;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  fetch_ptr <= mem_addr + 16'd1;
                  // Keep requesting only if the next byte is guaranteed a slot.
                  if (count_after < FULL) begin
                     mem_addr <= mem_addr + 16'd1;
                  end else begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (mem_ack) begin
                  state    <= REQ;
                  mem_addr <= fetch_ptr;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_reader.sv
// Bench for fetch_reader: a queue-based fetch model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_fetch_reader;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] load_addr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        instr_valid;
   logic [7:0]  instr_data;
   logic [15:0] instr_pc;
   logic        instr_ready;
   logic        force_en;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_reader #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_addr   (load_addr),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory: byte at address a is a[7:0]^0x3C unless overridden.
   assign mem_rdata = force_en ? 8'hAA : (mem_addr[7:0] ^ 8'h3C);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bytes the decoder will see, plus the one read on the bus.
   logic [23:0] q[$];
   logic        m_req;
   logic [15:0] m_addr;
   logic [15:0] m_fetch;
   logic        m_stale;
   int          m_n0;
   logic        m_pop;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_req   = 1'b0;
         m_addr  = 16'h0000;
         m_fetch = 16'h0000;
         m_stale = 1'b0;
      end else begin
         m_n0  = q.size();
         m_pop = (m_n0 > 0) && instr_ready && !load;
         if (load) begin
            q.delete();
            m_fetch = load_addr;
            if (!m_req || mem_ack) begin
               m_req   = 1'b1;
               m_addr  = load_addr;
               m_stale = 1'b0;
            end else begin
               m_stale = 1'b1;
            end
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_req && mem_ack) begin
               if (m_stale) begin
                  m_stale = 1'b0;
                  m_addr  = m_fetch;
               end else begin
                  q.push_back({mem_rdata, m_addr});
                  m_fetch = m_addr + 16'd1;
                  if (q.size() < DEPTH) m_addr = m_fetch;
                  else m_req = 1'b0;
               end
            end else if (!m_req && m_n0 < DEPTH) begin
               m_req  = 1'b1;
               m_addr = m_fetch;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_mem_req", 32'(mem_req), 32'(m_req));
         if (m_req) chk("model_mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("model_instr_valid", 32'(instr_valid), 32'(q.size() > 0));
         if (q.size() > 0) begin
            chk("model_instr_data", 32'(instr_data), 32'(q[0][23:16]));
            chk("model_instr_pc", 32'(instr_pc), 32'(q[0][15:0]));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int w;
      rst = 1'b1; load = 1'b0; load_addr = 16'h0000;
      mem_ack = 1'b1; instr_ready = 1'b1; force_en = 1'b0;
      repeat (2) tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_data", 32'(instr_data), 32'h00);
      chk("rst_instr_pc", 32'(instr_pc), 32'h0000);

      // Streaming with ack and ready tied high
      rst = 1'b0;
      tick();
      chk("first_req", 32'(mem_req), 32'd1);
      chk("first_addr", 32'(mem_addr), 32'h0000);
      tick();
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc0", 32'(instr_pc), 32'h0000);
      chk("stream_data0", 32'(instr_data), 32'h3C);
      tick();
      chk("stream_pc1", 32'(instr_pc), 32'h0001);
      chk("stream_data1", 32'(instr_data), 32'h3D);
      tick();
      chk("stream_pc2", 32'(instr_pc), 32'h0002);

      // Decoder stalled: FIFO fills with exactly DEPTH bytes
      rst = 1'b1;
      tick();
      rst = 1'b0; instr_ready = 1'b0;
      repeat (5) tick();
      chk("full_req_low", 32'(mem_req), 32'd0);
      chk("full_head_pc", 32'(instr_pc), 32'h0000);
      repeat (2) tick();
      chk("full_req_still_low", 32'(mem_req), 32'd0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      w = 0;
      while (!mem_req && w < 3) begin
         tick();
         w++;
      end
      chk("refill_req", 32'(mem_req), 32'd1);
      chk("refill_addr", 32'(mem_addr), 32'h0004);
      tick();
      chk("refill_single", 32'(mem_req), 32'd0);
      chk("refill_head_pc", 32'(instr_pc), 32'h0001);

      // Load near the top of memory, address wraps
      load = 1'b1; load_addr = 16'hFFFE; instr_ready = 1'b1;
      tick();
      load = 1'b0;
      chk("load_flush_valid", 32'(instr_valid), 32'd0);
      chk("load_req", 32'(mem_req), 32'd1);
      chk("load_addr_out", 32'(mem_addr), 32'hFFFE);
      tick();
      chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
      chk("wrap_data0", 32'(instr_data), 32'hC2);
      tick();
      chk("wrap_pc1", 32'(instr_pc), 32'hFFFF);
      tick();
      chk("wrap_pc2", 32'(instr_pc), 32'h0000);
      chk("wrap_data2", 32'(instr_data), 32'h3C);

      // Load while a request is outstanding: stale read is discarded
      load = 1'b1; load_addr = 16'h0010; mem_ack = 1'b1;
      tick();
      load = 1'b0; mem_ack = 1'b0;
      chk("pend_addr", 32'(mem_addr), 32'h0010);
      chk("pend_req", 32'(mem_req), 32'd1);
      tick();
      chk("pend_hold", 32'(mem_addr), 32'h0010);
      load = 1'b1; load_addr = 16'h0200;
      tick();
      load = 1'b0;
      chk("disc_hold0", 32'(mem_addr), 32'h0010);
      chk("disc_req", 32'(mem_req), 32'd1);
      chk("disc_valid0", 32'(instr_valid), 32'd0);
      tick();
      chk("disc_hold1", 32'(mem_addr), 32'h0010);
      tick();
      chk("disc_hold2", 32'(mem_addr), 32'h0010);
      mem_ack = 1'b1; force_en = 1'b1;
      tick();
      force_en = 1'b0;
      chk("disc_next_addr", 32'(mem_addr), 32'h0200);
      chk("disc_dropped", 32'(instr_valid), 32'd0);
      tick();
      chk("after_disc_pc", 32'(instr_pc), 32'h0200);
      chk("after_disc_data", 32'(instr_data), 32'h3C);

      // Load coinciding with ack and pop
      chk("pre_load_valid", 32'(instr_valid), 32'd1);
      load = 1'b1; load_addr = 16'h1234;
      tick();
      load = 1'b0;
      chk("coinc_valid", 32'(instr_valid), 32'd0);
      chk("coinc_addr", 32'(mem_addr), 32'h1234);
      tick();
      chk("coinc_pc", 32'(instr_pc), 32'h1234);
      chk("coinc_data", 32'(instr_data), 32'h08);

      // Asynchronous reset in the middle of a pending request
      instr_ready = 1'b0;
      tick();
      mem_ack = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("async_req", 32'(mem_req), 32'd0);
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_addr", 32'(mem_addr), 32'h0000);
      tick();
      rst = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
      tick();
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("restart_addr", 32'(mem_addr), 32'h0000);
      tick();
      chk("restart_pc", 32'(instr_pc), 32'h0000);

      // Irregular ack/ready pattern checked by the model
      for (int i = 0; i < 40; i++) begin
         instr_ready = (i % 3) != 0;
         mem_ack     = (i % 4) != 1;
         load        = (i == 25);
         load_addr   = 16'h0777;
         tick();
      end
      load = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_reader.md
Name: fetch_reader

Overview:
Instruction-fetch reader on the consumer side of the program-counter path: it tracks a 16-bit fetch address, issues byte reads to program memory over a req/ack handshake, and buffers returned bytes with their addresses in a small prefetch FIFO. The decoder pops bytes over a valid/ready handshake. A load (jump) redirects fetching and flushes all stale data, including a read already in flight. Sits between program memory and the instruction decoder.

Parameters:
DEPTH, 4, number of prefetch FIFO entries (power of 2, minimum 2); each entry holds 8-bit data plus a 16-bit address.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
load  input  1  redirect: flush the FIFO and restart fetching at load_addr
load_addr  input  16  new fetch address, sampled when load=1
mem_req  output  1  read request to program memory
mem_addr  output  16  read address; stable while mem_req=1
mem_ack  input  1  memory accepted the request; mem_rdata is valid in the same cycle
mem_rdata  input  8  read data
instr_valid  output  1  FIFO head is valid
instr_data  output  8  FIFO head byte
instr_pc  output  16  address of the FIFO head byte
instr_ready  input  1  decoder pops the head when instr_valid=1 and instr_ready=1

Behaviour:
- Reset (async assert): mem_req=0, mem_addr=0x0000, instr_valid=0, instr_data=0x00, instr_pc=0x0000, fetch_ptr=0x0000, FIFO empty, state=IDLE.
- States: IDLE (no read outstanding), REQ (mem_req=1, waiting for ack), DISCARD (mem_req=1 for a stale address, waiting for ack).
- IDLE -> REQ when occupancy < DEPTH and load=0. mem_addr=fetch_ptr, and mem_req rises on the next edge. The first request after reset release occurs one cycle after rst falls, at address 0x0000.
- REQ while mem_ack=1: push {mem_rdata, mem_addr} and set fetch_ptr = mem_addr + 1 (mod 2^16, so 0xFFFF wraps to 0x0000).
  - If space remains after the push, accounting for a same-cycle pop, stay in REQ with mem_addr advanced (back-to-back reads, one byte per cycle at best).
  - Otherwise go to IDLE with mem_req=0.
- Occupancy accounting: stored entries + outstanding request <= DEPTH. A new request is never issued if its data could not be stored.
- Pushed data is visible on instr_valid/instr_data/instr_pc on the cycle after the mem_ack edge, a latency of 1 cycle.
- Pop: instr_valid && instr_ready advances the head. Push and pop in the same cycle are both honoured and occupancy is unchanged.
- When empty: instr_valid=0, and instr_data/instr_pc hold their last values (don't-care).
- mem_req and mem_addr must not change while mem_req=1 and mem_ack=0. This holds even across a load: the request stays asserted on the old address.
- load (highest priority):
  - The FIFO is flushed and fetch_ptr=load_addr on the next edge.
  - A pop in the same cycle is ignored.
  - load in IDLE, or in REQ/DISCARD together with mem_ack=1: the ack's data is dropped, and the next state is REQ at load_addr.
  - load in REQ with mem_ack=0: go to DISCARD, keeping the old mem_addr and mem_req=1.
  - load in DISCARD with mem_ack=0: stay in DISCARD and update fetch_ptr to the newest load_addr.
- DISCARD with mem_ack=1: drop the data, then go to REQ with mem_addr=fetch_ptr on the next edge.
- instr_valid is 0 from the cycle after any load until the first byte at the new address is pushed. No byte fetched before the load is ever presented.
- Reset asserted mid-request: immediately return to reset values. A pending mem_ack is ignored.

Test Plan:
- Reset release, mem_ack tied 1, instr_ready=1 -> mem_req=1 at addr 0x0000 on cycle 1; instr_pc shows 0x0000, 0x0001, 0x0002... one per cycle, with matching mem_rdata.
- instr_ready=0, mem_ack=1 -> exactly DEPTH=4 acks (0x0000–0x0003); mem_req=0 afterwards. One pop -> a single new request at 0x0004.
- load with load_addr=0xFFFE, then run -> instr_pc 0xFFFE, 0xFFFF, 0x0000 (wrap).
- mem_req=1 at 0x0010 without ack, then load to 0x0200; ack 3 cycles later with data 0xAA -> mem_addr holds 0x0010 until the ack; 0xAA is never presented; the next request is 0x0200.
- load in the same cycle as mem_ack and instr_valid&&instr_ready -> instr_valid=0 on the next cycle, the acked byte is dropped, and the next mem_addr equals load_addr.
- Async rst pulsed mid-REQ (between clock edges) -> mem_req and instr_valid drop immediately; fetching restarts at 0x0000 after release.
